// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory page controller.
// Holds the command codes, the controller state codes and the erased-word value.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_ERASE  = 2'd1,
        OP_WRITE  = 2'd2,
        OP_CLRBUF = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ERASE  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam logic [15:0] ERASED_WORD = 16'hFFFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prog_mem_page_buf.sv
// Page buffer: one page worth of words staged by LOAD before a WRITE commit.
// Cleared to the erased value by reset, CLRBUF and a WRITE commit.
module prog_mem_page_buf
    import prog_mem_pkg::*;
#(
    parameter int PAGE_WORDS = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_en,
    input  logic [$clog2(PAGE_WORDS)-1:0]       load_idx,
    input  logic [15:0]                         load_data,
    input  logic                                clr,
    output logic [PAGE_WORDS-1:0][15:0]         words
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words <= {PAGE_WORDS{ERASED_WORD}};
        end else if (clr) begin
            words <= {PAGE_WORDS{ERASED_WORD}};
        end else if (load_en) begin
            words[load_idx] <= load_data;
        end
    end

endmodule

// File: rtl/prog_mem_page_ctrl.sv
// Program-memory page controller: instruction fetch port plus a page erase/write
// engine with read-while-write (RWW) and no-read-while-write (NRWW) sections.
module prog_mem_page_ctrl
    import prog_mem_pkg::*;
#(
    parameter int PAGE_WORDS   = 64,
    parameter int NUM_PAGES    = 256,
    parameter int NRWW_START   = 224,
    parameter int ERASE_CYCLES = 8,
    parameter int WRITE_CYCLES = 8,
    localparam int AW          = $clog2(PAGE_WORDS * NUM_PAGES) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          pc_rd,
    output logic [15:0]   instr,
    output logic          instr_valid,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [15:0]   cmd_data,
    output logic          busy,
    output logic          rww_busy,
    output logic          done,
    output logic          err
);

    // state  | meaning
    // IDLE   | accepting commands; fetches unrestricted
    // ERASE  | erase timer running on op_page
    // WRITE  | write timer running on op_page
    // COMMIT | op_page updated at end of this cycle, done pulses

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ERASE  = ST_ERASE;
    localparam logic [1:0] S_WRITE  = ST_WRITE;
    localparam logic [1:0] S_COMMIT = ST_COMMIT;

    localparam int WB        = $clog2(PAGE_WORDS);
    localparam int PB        = AW - WB;
    localparam int MEM_WORDS = PAGE_WORDS * NUM_PAGES;
    localparam int MA        = $clog2(MEM_WORDS);
    localparam int CW        = $clog2(max_int(ERASE_CYCLES, WRITE_CYCLES) + 1);

    logic [1:0]                  state;
    logic [CW-1:0]               cnt;
    logic [PB-1:0]               op_page;
    logic                        op_write;
    logic [15:0]                 mem [MEM_WORDS];
    logic [PAGE_WORDS-1:0][15:0] pbuf;

    cmd_op_e       op;
    logic [PB-1:0] cmd_page;
    logic [PB-1:0] pc_page;
    logic          accept;
    logic          is_prog;
    logic          cmd_in_range;
    logic          pc_in_range;
    logic          fetch_ok;

    assign op           = cmd_op_e'(cmd_op);
    assign cmd_page     = cmd_addr[AW-1:WB];
    assign pc_page      = pc[AW-1:WB];
    assign accept       = cmd_valid && cmd_ready;
    assign is_prog      = (op == OP_ERASE) || (op == OP_WRITE);
    assign cmd_in_range = cmd_page < PB'(NUM_PAGES);
    assign pc_in_range  = pc_page < PB'(NUM_PAGES);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rww_busy  = busy && (op_page < PB'(NRWW_START));
    assign done      = (state == S_COMMIT);

    // An NRWW operation blocks every fetch; an RWW operation only blocks RWW fetches.
    assign fetch_ok = pc_in_range &&
                      !(busy && (!rww_busy || (pc_page < PB'(NRWW_START))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_page  <= '0;
            op_write <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= accept && is_prog && !cmd_in_range;
            case (state)
                S_IDLE: begin
                    if (accept && is_prog && cmd_in_range) begin
                        op_page  <= cmd_page;
                        op_write <= (op == OP_WRITE);
                        if (op == OP_WRITE) begin
                            state <= S_WRITE;
                            cnt   <= CW'(WRITE_CYCLES - 1);
                        end else begin
                            state <= S_ERASE;
                            cnt   <= CW'(ERASE_CYCLES - 1);
                        end
                    end
                end
                S_ERASE, S_WRITE: begin
                    if (cnt == '0) begin
                        state <= S_COMMIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Array is non-volatile: no reset, only the commit cycle writes it.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_COMMIT)) begin
            for (int w = 0; w < PAGE_WORDS; w++) begin
                if (op_write) begin
                    mem[MA'({op_page, WB'(w)})] <= mem[MA'({op_page, WB'(w)})] & pbuf[WB'(w)];
                end else begin
                    mem[MA'({op_page, WB'(w)})] <= ERASED_WORD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= pc_rd && fetch_ok;
            if (pc_rd && fetch_ok) begin
                instr <= mem[pc[MA-1:0]];
            end
        end
    end

    prog_mem_page_buf #(
        .PAGE_WORDS (PAGE_WORDS)
    ) u_page_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (accept && (op == OP_LOAD)),
        .load_idx  (cmd_addr[WB-1:0]),
        .load_data (cmd_data),
        .clr       ((accept && (op == OP_CLRBUF)) || (done && op_write)),
        .words     (pbuf)
    );

endmodule

// File: tb/tb_prog_mem_page_ctrl.sv
// Bench for prog_mem_page_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a page-level reference model.
module tb_prog_mem_page_ctrl;
    import prog_mem_pkg::*;

    localparam int PW   = 64;
    localparam int NP   = 256;
    localparam int NRWW = 224;
    localparam int EC   = 8;
    localparam int WC   = 8;
    localparam int AW   = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc = '0;
    logic          pc_rd = 1'b0;
    logic [15:0]   instr;
    logic          instr_valid;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [15:0]   cmd_data = '0;
    logic          busy, rww_busy, done, err;

    always #5 clk = ~clk;

    prog_mem_page_ctrl #(
        .PAGE_WORDS   (PW),
        .NUM_PAGES    (NP),
        .NRWW_START   (NRWW),
        .ERASE_CYCLES (EC),
        .WRITE_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_rd       (pc_rd),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .rww_busy    (rww_busy),
        .done        (done),
        .err         (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-page memory image, staging buffer, one pending operation
    // described by its page and the number of cycles left until its done cycle.
    logic [15:0] m_mem [NP*PW];
    bit          m_known [NP];
    logic [15:0] m_buf [PW];
    bit          op_active = 1'b0;
    bit          op_write  = 1'b0;
    int          op_page   = 0;
    int          op_rem    = 0;
    bit          e_valid   = 1'b0;
    bit          e_known   = 1'b0;
    bit          e_err     = 1'b0;
    logic [15:0] e_instr   = '0;
    int          m_pg, m_cpg;
    bit          m_was_active;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            op_active = 1'b0;
            e_valid   = 1'b0;
            e_err     = 1'b0;
            e_instr   = '0;
            for (int w = 0; w < PW; w++) m_buf[w] = 16'hFFFF;
        end else begin
            m_was_active = op_active;
            m_pg = int'(pc) / PW;
            e_valid = pc_rd && (m_pg < NP) &&
                      !(m_was_active && ((op_page >= NRWW) || (m_pg < NRWW)));
            if (e_valid) begin
                e_instr = m_mem[int'(pc)];
                e_known = m_known[m_pg];
            end
            e_err = 1'b0;
            if (m_was_active) begin
                if (op_rem == 0) begin
                    for (int w = 0; w < PW; w++) begin
                        if (op_write) m_mem[op_page*PW + w] = m_mem[op_page*PW + w] & m_buf[w];
                        else          m_mem[op_page*PW + w] = 16'hFFFF;
                    end
                    if (op_write) for (int w = 0; w < PW; w++) m_buf[w] = 16'hFFFF;
                    else          m_known[op_page] = 1'b1;
                    op_active = 1'b0;
                end else begin
                    op_rem--;
                end
            end else if (cmd_valid) begin
                m_cpg = int'(cmd_addr) / PW;
                case (cmd_op)
                    2'd0: m_buf[int'(cmd_addr) % PW] = cmd_data;
                    2'd3: for (int w = 0; w < PW; w++) m_buf[w] = 16'hFFFF;
                    default: begin
                        if (m_cpg >= NP) begin
                            e_err = 1'b1;
                        end else begin
                            op_active = 1'b1;
                            op_write  = (cmd_op == 2'd2);
                            op_page   = m_cpg;
                            op_rem    = op_write ? WC : EC;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("instr_valid", {15'd0, instr_valid}, {15'd0, e_valid});
            if (e_valid && e_known) check("instr", instr, e_instr);
            check("busy",      {15'd0, busy},      {15'd0, op_active});
            check("rww_busy",  {15'd0, rww_busy},  {15'd0, op_active && (op_page < NRWW)});
            check("done",      {15'd0, done},      {15'd0, op_active && (op_rem == 0)});
            check("cmd_ready", {15'd0, cmd_ready}, {15'd0, !op_active});
            check("err",       {15'd0, err},       {15'd0, e_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input int addr, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = AW'(addr);
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 200) begin
            step();
            lat++;
        end
        check("done_seen", {15'd0, done}, 16'd1);
        step();
    endtask

    task automatic fetch(input int addr, output logic v, output logic [15:0] d);
        pc    = AW'(addr);
        pc_rd = 1'b1;
        step();
        v     = instr_valid;
        d     = instr;
        pc_rd = 1'b0;
    endtask

    int          rnd_pages [9] = '{0, 1, 2, 3, 222, 223, 224, 225, 255};

    function automatic logic [AW-1:0] rand_addr();
        int p;
        if ($urandom_range(0, 9) == 0) p = int'($urandom_range(256, 511));
        else                           p = rnd_pages[$urandom_range(0, 8)];
        return AW'(p * PW + int'($urandom_range(0, PW - 1)));
    endfunction

    initial begin
        int          lat;
        logic        v;
        logic [15:0] d;

        repeat (2) @(posedge clk);
        #1;
        check("rst_instr",       instr,                  16'h0000);
        check("rst_instr_valid", {15'd0, instr_valid},   16'd0);
        check("rst_busy",        {15'd0, busy},          16'd0);
        check("rst_rww_busy",    {15'd0, rww_busy},      16'd0);
        check("rst_done",        {15'd0, done},          16'd0);
        check("rst_err",         {15'd0, err},           16'd0);
        check("rst_cmd_ready",   {15'd0, cmd_ready},     16'd1);
        rst    = 1'b0;
        chk_en = 1'b1;

        foreach (rnd_pages[i]) begin
            issue(OP_ERASE, rnd_pages[i] * PW, 16'h0);
            wait_done(lat);
        end

        // Erase then fetch
        issue(OP_ERASE, 'h0040, 16'h0);
        wait_done(lat);
        check("erase_latency", 16'(lat), 16'd9);
        fetch('h0041, v, d);
        check("erase_fetch_valid", {15'd0, v}, 16'd1);
        check("erase_fetch_data", d, 16'hFFFF);

        // Load, write, fetch; then a write with the buffer back at erased value
        issue(OP_LOAD, 'h0041, 16'h6699);
        issue(OP_WRITE, 'h0040, 16'h0);
        wait_done(lat);
        check("write_latency", 16'(lat), 16'd9);
        fetch('h0041, v, d);
        check("write_fetch_data", d, 16'h6699);
        check("model_pin_6699", m_mem['h0041], 16'h6699);
        issue(OP_WRITE, 'h0080, 16'h0);
        wait_done(lat);
        fetch('h0081, v, d);
        check("buf_cleared_after_write", d, 16'hFFFF);

        // RWW blocking with NRWW fetch proceeding
        issue(OP_ERASE, 'h3840, 16'h0);
        wait_done(lat);
        issue(OP_LOAD, 'h3841, 16'hF69F);
        issue(OP_WRITE, 'h3840, 16'h0);
        wait_done(lat);
        issue(OP_LOAD, 'h0041, 16'h0F0F);
        issue(OP_WRITE, 'h0040, 16'h0);
        check("rww_busy_page1", {15'd0, rww_busy}, 16'd1);
        fetch('h0041, v, d);
        check("rww_fetch_stalled", {15'd0, v}, 16'd0);
        fetch('h3841, v, d);
        check("nrww_fetch_valid", {15'd0, v}, 16'd1);
        check("nrww_fetch_data", d, 16'hF69F);
        wait_done(lat);
        fetch('h0041, v, d);
        check("and_page1", d, 16'h0609);

        // NRWW blocking and AND semantics
        issue(OP_LOAD, 'h3842, 16'h00FF);
        issue(OP_WRITE, 'h3840, 16'h0);
        wait_done(lat);
        issue(OP_LOAD, 'h3842, 16'hFF0F);
        issue(OP_WRITE, 'h3840, 16'h0);
        check("nrww_rww_busy", {15'd0, rww_busy}, 16'd0);
        fetch('h0041, v, d);
        check("nrww_blocks_rww", {15'd0, v}, 16'd0);
        fetch('h3841, v, d);
        check("nrww_blocks_nrww", {15'd0, v}, 16'd0);
        wait_done(lat);
        fetch('h3842, v, d);
        check("and_result", d, 16'h000F);
        check("model_pin_000f", m_mem['h3842], 16'h000F);
        fetch('h3841, v, d);
        check("neighbour_kept", d, 16'hF69F);

        // Reset in cycle 3 of an ERASE leaves the page intact
        issue(OP_ERASE, 'h0040, 16'h0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_ready", {15'd0, cmd_ready}, 16'd1);
        step();
        step();
        rst = 1'b0;
        fetch('h0041, v, d);
        check("abort_page_kept", d, 16'h0609);

        // Out-of-range commands and fetch
        issue(OP_ERASE, 'h4000, 16'h0);
        check("range_err", {15'd0, err}, 16'd1);
        check("range_no_busy", {15'd0, busy}, 16'd0);
        step();
        check("range_err_pulse", {15'd0, err}, 16'd0);
        issue(OP_WRITE, 'h7FC0, 16'h0);
        check("range_err_write", {15'd0, err}, 16'd1);
        fetch('h4001, v, d);
        check("range_fetch", {15'd0, v}, 16'd0);

        // Randomized traffic, including commands while busy and sporadic resets
        for (int i = 0; i < 4000; i++) begin
            pc        = rand_addr();
            pc_rd     = ($urandom_range(0, 3) != 0);
            cmd_valid = ($urandom_range(0, 5) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_addr  = rand_addr();
            cmd_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'($urandom) | 16'hF0F0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            step();
        end
        cmd_valid = 1'b0;
        pc_rd     = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
